// File: rtl/elastic_stage_register_pkg.sv
// Shared types and default bundle widths for the elastic pipeline-stage register.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_e;

  localparam int ESR_MAX_STAGES = 4;

  // Memory -> writeback bundle widths, so stage wrappers can instantiate by name.
  localparam int MW_CTRL_W = 8;
  localparam int MW_DATA_W = 101;

  function automatic logic [1:0] slice_count(slice_state_e s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_stage_register_if.sv
// valid/ready handshake bundle between two pipeline stages, upstream and downstream sides.
interface elastic_stage_register_if
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = MW_CTRL_W,
  parameter int DATA_W = MW_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/elastic_stage_register_slice.sv
// One 2-entry skid slice: main register feeds downstream, skid absorbs one entry of back-pressure.
module elastic_stage_slice
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = MW_CTRL_W,
  parameter int DATA_W = MW_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  slice_state_e      state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              accept, pop;

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
  assign out_data_o  = main_data_q;
  assign count_o     = slice_count(state_q);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Data registers keep their contents on flush so out_data holds its last value.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end else if (accept) begin
            state_d     = TWO;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/elastic_stage_register.sv
// Flushable, back-pressure-aware pipeline register built from STAGES chained skid slices.
// Optional stall counter output enabled by defining ESR_STALL_CNT_EN.
module elastic_stage_register
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = MW_CTRL_W,
  parameter int DATA_W = MW_DATA_W,
  parameter int STAGES = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  elastic_stage_register_if.slave          bus,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
`ifdef ESR_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int OCC_W = $clog2(2*STAGES+1);

  logic [STAGES:0]   link_valid;
  logic [STAGES:0]   link_ready;
  logic [CTRL_W-1:0] link_ctrl [STAGES+1];
  logic [DATA_W-1:0] link_data [STAGES+1];
  logic [1:0]        slice_cnt [STAGES];
  logic [OCC_W-1:0]  occ_sum;

  assign link_valid[0]      = bus.in_valid;
  assign link_ctrl[0]       = bus.in_ctrl;
  assign link_data[0]       = bus.in_data;
  assign bus.in_ready       = link_ready[0];
  assign bus.out_valid      = link_valid[STAGES];
  assign bus.out_ctrl       = link_ctrl[STAGES];
  assign bus.out_data       = link_data[STAGES];
  assign link_ready[STAGES] = bus.out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    elastic_stage_slice #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slice (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid_i  (link_valid[g]),
      .in_ready_o  (link_ready[g]),
      .in_ctrl_i   (link_ctrl[g]),
      .in_data_i   (link_data[g]),
      .out_valid_o (link_valid[g+1]),
      .out_ready_i (link_ready[g+1]),
      .out_ctrl_o  (link_ctrl[g+1]),
      .out_data_o  (link_data[g+1]),
      .count_o     (slice_cnt[g])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(slice_cnt[i]);
    end
  end

  assign occupancy = occ_sum;

`ifdef ESR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where downstream holds off a presented entry; flush leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (bus.out_valid && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
